temporal_encoder: RTL and testbench

TEMPORAL_ENCODER -- requirements
Module: temporal_encoder

---
 rtl/temporal_encoder.sv | 118 +++++++++++
 tb/tb_temporal_encoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_encoder.sv
`default_nettype none
// ============================================================================
// Module      : temporal_encoder
// Description : Converts a spike-time value into race-logic temporal codes
//               (rising edge, falling edge, fixed-width pulse) aligned to a
//               repeating gamma cycle. Values are staged through a 1-deep
//               pending register and only take effect at gamma boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module temporal_encoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int VAL_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VAL_WIDTH-1:0] in_value,
  output logic                 set,
  output logic                 edge_rise,
  output logic                 edge_fall,
  output logic                 pulse_out,
  output logic                 gamma_done
);

  localparam int TICK_W = $clog2(GAMMA_CYCLE_WIDTH);
  // Comparison width wide enough for act_val + PULSE_WIDTH without overflow.
  localparam int CMP_W  = ((VAL_WIDTH > TICK_W) ? VAL_WIDTH : TICK_W) + 2;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CMP_W-1:0]  GAMMA_C   = CMP_W'(GAMMA_CYCLE_WIDTH);
  localparam logic [CMP_W-1:0]  PULSE_C   = CMP_W'(PULSE_WIDTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } state_t;

  // Registered state. 'running' is clear while in reset and for the cycle
  // before the first edge after release, so that edge loads tick 0 outputs.
  logic                 running;
  logic [TICK_W-1:0]    tick;
  logic                 pend_valid;
  logic [VAL_WIDTH-1:0] pend_val;
  state_t               state;
  logic [VAL_WIDTH-1:0] act_val;

  // Next-cycle view used to precompute the flopped outputs.
  logic                 at_last;
  logic                 transfer;
  logic [TICK_W-1:0]    nxt_tick;
  state_t               nxt_state;
  logic [VAL_WIDTH-1:0] nxt_act_val;
  logic [CMP_W-1:0]     nxt_tick_c;
  logic [CMP_W-1:0]     nxt_val_c;
  logic                 nxt_hit;
  logic                 nxt_rise;
  logic                 nxt_pulse;

  assign at_last  = running & (tick == LAST_TICK);
  assign in_ready = ~pend_valid | (tick == LAST_TICK);
  assign transfer = in_valid & in_ready;

  // Derive the tick, active value and temporal codes of the coming cycle.
  always_comb begin
    nxt_tick    = '0;
    nxt_state   = state;
    nxt_act_val = act_val;
    if (running && !at_last) begin
      nxt_tick = tick + 1'b1;
    end
    if (at_last) begin
      nxt_state   = pend_valid ? ENCODE : IDLE;
      nxt_act_val = pend_val;
    end
    nxt_tick_c = CMP_W'(nxt_tick);
    nxt_val_c  = CMP_W'(nxt_act_val);
    nxt_hit    = (nxt_state == ENCODE) && (nxt_val_c < GAMMA_C);
    nxt_rise   = nxt_hit && (nxt_tick_c >= nxt_val_c);
    // Tick never exceeds the last tick, so the pulse is truncated naturally.
    nxt_pulse  = nxt_rise && (nxt_tick_c < (nxt_val_c + PULSE_C));
  end

  // Tick counter, pending/active staging, encode FSM and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running    <= 1'b0;
      tick       <= '0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      state      <= IDLE;
      act_val    <= '0;
      set        <= 1'b0;
      edge_rise  <= 1'b0;
      edge_fall  <= 1'b1;
      pulse_out  <= 1'b0;
      gamma_done <= 1'b0;
    end else begin
      running <= 1'b1;
      tick    <= nxt_tick;
      state   <= nxt_state;
      act_val <= nxt_act_val;
      if (transfer) begin
        pend_valid <= 1'b1;
        pend_val   <= in_value;
      end else if (at_last) begin
        pend_valid <= 1'b0;
      end
      set        <= (nxt_tick == '0);
      gamma_done <= (nxt_tick == LAST_TICK);
      edge_rise  <= nxt_rise;
      edge_fall  <= ~nxt_rise;
      pulse_out  <= nxt_pulse;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_temporal_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_temporal_encoder
// Description : Self-checking bench for temporal_encoder using a cycle-level
//               reference model of gamma ticks and pending/active values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int P  = 8;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_value;
  logic          set, edge_rise, edge_fall, pulse_out, gamma_done;

  temporal_encoder #(
    .GAMMA_CYCLE_WIDTH(G),
    .PULSE_WIDTH      (P),
    .VAL_WIDTH        (VW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .set       (set),
    .edge_rise (edge_rise),
    .edge_fall (edge_fall),
    .pulse_out (pulse_out),
    .gamma_done(gamma_done)
  );

  always #5 clk = ~clk;

  // Reference model: cycle position within the gamma cycle plus the value
  // waiting for the next boundary and the value governing the current gamma.
  bit started;
  int m_tick;
  bit mp_valid;
  int mp_val;
  bit ma_valid;
  int ma_val;
  bit last_xfer;

  int npass  = 0;
  int ntotal = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s t=%0t tick=%0d observed=%b expected=%b", tag, $time, m_tick, obs, exp);
  endtask

  task automatic model_reset();
    started  = 0;
    m_tick   = 0;
    mp_valid = 0;
    ma_valid = 0;
  endtask

  task automatic check_outputs();
    bit hit, rise, pulse;
    if (!started) begin
      check("set_rst",   set,        1'b0);
      check("rise_rst",  edge_rise,  1'b0);
      check("fall_rst",  edge_fall,  1'b1);
      check("pulse_rst", pulse_out,  1'b0);
      check("done_rst",  gamma_done, 1'b0);
    end else begin
      hit   = ma_valid && (ma_val < G);
      rise  = hit && (m_tick >= ma_val);
      pulse = hit && (m_tick >= ma_val) && (m_tick < ma_val + P);
      check("set",       set,        m_tick == 0);
      check("gamma_done", gamma_done, m_tick == G - 1);
      check("edge_rise", edge_rise,  rise);
      check("edge_fall", edge_fall,  !rise);
      check("pulse_out", pulse_out,  pulse);
    end
  endtask

  // One clock: check in_ready, advance the model across the edge, check outputs.
  task automatic step();
    bit exp_ready, xfer;
    exp_ready = !mp_valid || (started && m_tick == G - 1);
    check("in_ready", in_ready, exp_ready);
    xfer = in_valid && exp_ready;
    @(posedge clk);
    if (!rst) begin
      if (!started) begin
        started = 1;
        m_tick  = 0;
      end else if (m_tick == G - 1) begin
        ma_valid = mp_valid;
        ma_val   = mp_val;
        mp_valid = 0;
        m_tick   = 0;
      end else begin
        m_tick++;
      end
      if (xfer) begin
        mp_valid = 1;
        mp_val   = int'(in_value);
      end
    end
    last_xfer = xfer;
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer a value and hold it until accepted.
  task automatic send(input int v);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_value  = VW'(v);
    last_xfer = 0;
    while (!last_xfer && guard < 100) begin
      step();
      guard++;
    end
    if (!last_xfer) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_tick(input int t);
    int guard;
    guard = 0;
    while (!(started && m_tick == t) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("wait_tick_timeout", 1'b0, 1'b1);
  endtask

  // Asynchronous reset pulse away from the clock edge.
  task automatic pulse_reset();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("in_ready_rst", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    model_reset();
    #12;
    check_outputs();
    check("in_ready_rst", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Idle gammas: only set/gamma_done strobes.
    run(40);

    // Value 5 at tick 3, then value 12, value 0, value 20.
    wait_tick(3);
    send(5);
    wait_tick(0);
    run(G);
    send(12);
    wait_tick(0);
    run(G);
    send(0);
    wait_tick(0);
    run(2);
    send(20);
    wait_tick(0);
    run(2 * G);

    // Back-to-back values with the producer held by in_ready.
    send(3);
    send(7);
    send(20);
    run(4 * G);

    // Mid-gamma reset during an encode of value 4.
    send(4);
    guard = 0;
    while (!(ma_valid && ma_val == 4 && m_tick == 9) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("wait_encode_timeout", 1'b0, 1'b1);
    pulse_reset();
    run(3 * G);

    // Randomized producer traffic.
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b1;
        in_value = VW'($urandom_range(0, 31));
      end
      step();
      if (last_xfer) in_valid = 1'b0;
      if (i == 317) pulse_reset();
    end
    in_valid = 1'b0;
    run(2 * G);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
